// File: rtl/serial_alu_sequencer_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: ALU op select and FSM states.
package serial_alu_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_AND   = 2'd0,
    OP_OR    = 2'd1,
    OP_ADD   = 2'd2,
    OP_PASSB = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_alu_sequencer_alu_bit_slice.sv
// One-bit ALU slice: AND / OR / full-add / transfer-B chosen by a 4:1 select.
module alu_bit_slice
  import serial_alu_sequencer_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] sel,
  output logic       res,
  output logic       cout
);

  always_comb begin
    res = 1'b0;
    case (sel)
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_ADD:   res = a ^ b ^ cin;
      OP_PASSB: res = b;
    endcase
  end

  // Carry is produced for every op; the sequencer decides whether it matters.
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: latches operands, walks a 1-bit slice LSB-first
// for WIDTH cycles with a rippled carry flop, then publishes result and flags.
module serial_alu_sequencer
  import serial_alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ALUOp,
  input  logic             Binvert,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_p0, bx_p0, acc_p0;
  alu_op_e          op_p0;
  logic             accept, last_bit, shifting;
  logic             bit_res, bit_cout;
  logic [WIDTH-1:0] word;

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign shifting = (state_q == S_SHIFT);

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start && !Reset) begin
          accept  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        Busy = 1'b1;
        if (last_bit) state_d = S_DONE;
      end
      S_DONE: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 0: operand capture on an accepted Start
  always_ff @(posedge Clk) begin
    if (accept) begin
      a_p0  <= A;
      bx_p0 <= B ^ {WIDTH{Binvert}};
      op_p0 <= alu_op_e'(ALUOp);
    end
  end

  alu_bit_slice u_slice (
    .a    (a_p0[cnt_q]),
    .b    (bx_p0[cnt_q]),
    .cin  (carry_q),
    .sel  (op_p0),
    .res  (bit_res),
    .cout (bit_cout)
  );

  // Partial word lives only here; the Result port sees it once complete.
  always_ff @(posedge Clk) begin
    if (shifting) acc_p0[cnt_q] <= bit_res;
  end

  always_comb begin
    word        = acc_p0;
    word[cnt_q] = bit_res;
  end

  // Stage 1: serial control and published result/flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      Result   <= '0;
      Zero     <= 1'b1;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      carry_q <= Binvert;
    end else if (shifting) begin
      carry_q <= bit_cout;
      if (last_bit) begin
        cnt_q    <= '0;
        Result   <= word;
        Zero     <= (word == '0);
        CarryOut <= (op_p0 == OP_ADD) & bit_cout;
        Overflow <= (op_p0 == OP_ADD) & (carry_q ^ bit_cout);
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Scoreboard bench for serial_alu_sequencer: driver queues expected words from
// an arithmetic model, a monitor pops and compares on every Done pulse.
module tb_serial_alu_sequencer;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset, Start, Binvert;
  logic [W-1:0] A, B;
  logic [1:0]   ALUOp;
  logic         Busy, Done, Zero, CarryOut, Overflow;
  logic [W-1:0] Result;

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B), .ALUOp(ALUOp),
    .Binvert(Binvert), .Busy(Busy), .Done(Done), .Result(Result), .Zero(Zero),
    .CarryOut(CarryOut), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         z, c, v;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           compared = 0;
  int           mismatched = 0;
  logic [W-1:0] last_res = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input logic binv, input int acc);
    exp_t         e;
    logic [W-1:0] bx;
    logic [W:0]   sum;
    bx    = binv ? ~b : b;
    e.c   = 1'b0;
    e.v   = 1'b0;
    e.acc = acc;
    case (op)
      2'd0: e.res = a & bx;
      2'd1: e.res = a | bx;
      2'd2: begin
        sum   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, binv};
        e.res = sum[W-1:0];
        e.c   = sum[W];
        e.v   = (a[W-1] == bx[W-1]) && (e.res[W-1] != a[W-1]);
      end
      default: e.res = bx;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset !== 1'b0) begin
        prev_done = 1'b0;
      end else begin
        if (Done === 1'b1) begin
          check("done_single_pulse", {31'b0, prev_done}, 0);
          if (q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_done: got Done=1 Result=%h required no pending op", Result);
          end else begin
            e = q.pop_front();
            check("result",   Result, e.res);
            check("zero",     {31'b0, Zero},     {31'b0, e.z});
            check("carryout", {31'b0, CarryOut}, {31'b0, e.c});
            check("overflow", {31'b0, Overflow}, {31'b0, e.v});
            check("latency",  W'(cyc - e.acc), W'(W));
            check("busy_at_done", {31'b0, Busy}, 1);
            last_res = e.res;
          end
        end else begin
          check("result_hold", Result, last_res);
        end
        prev_done = (Done === 1'b1);
      end
    end
  end

  task automatic reset_state(input string tag);
    check({tag, "_busy"},     {31'b0, Busy},     0);
    check({tag, "_done"},     {31'b0, Done},     0);
    check({tag, "_result"},   Result,            0);
    check({tag, "_zero"},     {31'b0, Zero},     1);
    check({tag, "_carryout"}, {31'b0, CarryOut}, 0);
    check({tag, "_overflow"}, {31'b0, Overflow}, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy !== 1'b0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 200) bound_fail("wait_idle");
  endtask

  task automatic scramble();
    A       = $urandom;
    B       = $urandom;
    ALUOp   = 2'($urandom_range(0, 3));
    Binvert = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic binv);
    wait_idle();
    A = a; B = b; ALUOp = op; Binvert = binv; Start = 1'b1;
    q.push_back(model(a, b, op, binv, cyc + 1));
    @(negedge Clk);
    Start = 1'b0;
    scramble();
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || Busy !== 1'b0) && n < 500) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 500) bound_fail("drain");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Start = 1'b1;
    scramble();
    repeat (3) @(negedge Clk);
    reset_state("por");
    Reset = 1'b0; Start = 1'b0;
    @(negedge Clk);

    // Reset during cycle 10 of an ADD, then a normal op
    issue($urandom, $urandom, 2'd2, 1'b0);
    repeat (9) @(negedge Clk);
    Reset = 1'b1; Start = 1'b1;
    @(posedge Clk);
    #1;
    q.delete();
    last_res = '0;
    @(negedge Clk);
    reset_state("midshift");
    Reset = 1'b0; Start = 1'b0;
    issue(32'd100, 32'd23, 2'd2, 1'b0);

    // Directed arithmetic and logic cases
    issue(32'h7FFF_FFFF, 32'd1, 2'd2, 1'b0);
    issue(32'd5, 32'd5, 2'd2, 1'b1);
    issue(32'd0, 32'd1, 2'd2, 1'b1);
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, 2'd0, 1'b0);
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, 2'd1, 1'b0);
    issue($urandom, 32'h1234_5678, 2'd3, 1'b0);
    issue(32'hFFFF_FFFF, 32'd1, 2'd2, 1'b0);
    issue(32'h8000_0000, 32'd1, 2'd2, 1'b1);
    issue(32'h0F0F_0000, 32'h00FF_00FF, 2'd1, 1'b1);

    // Start during SHIFT and during DONE must be ignored
    issue(32'hDEAD_BEEF, 32'h0000_FFFF, 2'd0, 1'b0);
    repeat (5) @(negedge Clk);
    Start = 1'b1; A = 32'h1111_1111; B = 32'h2222_2222; ALUOp = 2'd2;
    @(negedge Clk);
    Start = 1'b0;
    begin
      int n = 0;
      while (Done !== 1'b1 && n < 100) begin
        @(negedge Clk);
        n++;
      end
      if (n >= 100) bound_fail("wait_done");
    end
    Start = 1'b1; A = 32'h3333_3333; B = 32'h4444_4444; ALUOp = 2'd1;
    @(negedge Clk);
    Start = 1'b0;
    check("idle_after_done", {31'b0, Busy}, 0);
    repeat (3) @(negedge Clk);
    check("no_spurious_start", {31'b0, Busy}, 0);

    // Start held high: one accept every W+2 cycles
    wait_idle();
    scramble();
    Start = 1'b1;
    q.push_back(model(A, B, ALUOp, Binvert, cyc + 1));
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      scramble();
      q.push_back(model(A, B, ALUOp, Binvert, cyc + W + 2));
      repeat (W + 1) @(negedge Clk);
    end
    @(negedge Clk);
    Start = 1'b0;

    // Randomized ops
    for (int i = 0; i < 30; i++)
      issue($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    drain();
    check("queue_empty", W'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
